// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scan controller.
// Contents: FSM state enum, column reset pattern, key map, and one-hot helpers
// used by the controller for row/column decoding.
package keypad_pkg;

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    CONFIRM,
    EMIT,
    HOLD
  } state_e;

  localparam logic [3:0] COL_RESET = 4'b0001;

  // Physical keypad legend, row-major:
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
  function automatic logic [3:0] key_map(input logic [1:0] row_idx,
                                         input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // True when exactly one bit is set; zero and multi-row (ghosting) both fail.
  function automatic bit onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Index of the set bit in a one-hot nibble (only meaningful for one-hot input).
  function automatic logic [1:0] idx4(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Column advance: 1000 wraps back to 0001.
  function automatic logic [3:0] rotl4(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: free-running modulo-LIMIT counter with a terminal-count strobe.
// Ports: clk, reset (async, active-high), clear (sync, wins over enable),
//        enable (count this cycle), done (comb: enabled cycle at count LIMIT-1).
module cycle_timer #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned WIDTH = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             at_term;

  assign at_term = (cnt_q == TERM);
  assign done    = enable && !clear && at_term;

  // Wraps to zero on its own at terminal count so back-to-back periods need
  // no explicit clear from the owner.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = at_term ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scan, press/release debounce, and one
// key event per press over a valid/ready handshake.
// Ports: clk, reset (async, active-high), rows (synchronized, active-high),
//        cols (one-hot drive), key_code/key_valid/key_ready (event handshake),
//        key_held (accepted key still down). All outputs are registered.
// SCAN_DIV must be >= 2 and DEBOUNCE_CYCLES >= 1.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 48000,
  parameter int unsigned DEBOUNCE_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e     state_q;
  logic [3:0] cols_q;
  logic [3:0] code_q;
  logic       valid_q;
  logic       held_q;
  logic [1:0] row_idx_q;
  logic [1:0] col_idx_q;

  logic       rows_zero;
  logic       row_match;
  logic       div_en;
  logic       div_clear;
  logic       div_done;
  logic       tmr_en;
  logic       tmr_clear;
  logic       tmr_done;

  assign rows_zero = (rows == 4'd0);
  assign row_match = (rows == (4'b0001 << row_idx_q));

  // Divider only runs in SCAN and sits at zero elsewhere, so every entry to
  // SCAN starts a full column period.
  assign div_en    = (state_q == SCAN);
  assign div_clear = (state_q != SCAN);

  // One timer serves both press debounce and release debounce. It is held at
  // zero outside those states so it always starts fresh on entry; in HOLD any
  // nonzero row sample restarts the release window.
  assign tmr_en    = (state_q == DEBOUNCE) || ((state_q == HOLD) && rows_zero);
  assign tmr_clear = !((state_q == DEBOUNCE) || (state_q == HOLD)) ||
                     ((state_q == HOLD) && !rows_zero);

  cycle_timer #(
    .LIMIT (SCAN_DIV),
    .WIDTH (CNT_W)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (div_clear),
    .enable (div_en),
    .done   (div_done)
  );

  cycle_timer #(
    .LIMIT (DEBOUNCE_CYCLES),
    .WIDTH (CNT_W)
  ) u_tmr (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .done   (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SCAN;
      cols_q    <= COL_RESET;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
    end else begin
      case (state_q)
        SCAN: begin
          if (div_done) begin
            if (onehot4(rows)) begin
              // Exactly one row active: remember the key position and keep
              // this column driven through debounce and hold.
              row_idx_q <= idx4(rows);
              col_idx_q <= idx4(cols_q);
              state_q   <= DEBOUNCE;
            end else begin
              // Idle or ambiguous (multiple rows): move on to the next column.
              cols_q <= rotl4(cols_q);
            end
          end
        end

        DEBOUNCE: begin
          if (tmr_done) begin
            state_q <= CONFIRM;
          end
        end

        CONFIRM: begin
          if (row_match) begin
            code_q  <= key_map(row_idx_q, col_idx_q);
            valid_q <= 1'b1;
            state_q <= EMIT;
          end else begin
            // Bounce or release during debounce: rescan the same column.
            state_q <= SCAN;
          end
        end

        EMIT: begin
          // Event is committed once confirmed; releasing the key here does
          // not withdraw it.
          if (key_ready) begin
            valid_q <= 1'b0;
            held_q  <= 1'b1;
            state_q <= HOLD;
          end
        end

        HOLD: begin
          if (tmr_done) begin
            held_q  <= 1'b0;
            cols_q  <= rotl4(cols_q);
            state_q <= SCAN;
          end
        end

        default: begin
          state_q <= SCAN;
          cols_q  <= COL_RESET;
          valid_q <= 1'b0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cols      = cols_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 10;

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;

  int total;
  int bad;
  int xfers;

  typedef struct {
    logic [3:0] rows;
    logic       rdy;
    logic [3:0] cols;
    logic       vld;
    logic [3:0] code;
    logic       held;
  } vec_t;

  vec_t tbl [41];

  keypad_scan_ctrl #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; leaves reset released at a negedge, before the
  // first active edge of the new run.
  task automatic do_reset();
    reset     = 1'b1;
    rows      = 4'd0;
    key_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    xfers = 0;
  endtask

  // Drive one cycle of inputs at a negedge, clock once, return at the next
  // negedge where outputs are sampled.
  task automatic step(input logic [3:0] r, input logic rdy);
    rows      = r;
    key_ready = rdy;
    if (key_valid && key_ready) xfers++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] one;
    total = 0;
    bad   = 0;
    xfers = 0;
    reset = 1'b1;
    rows  = 4'd0;
    key_ready = 1'b0;
    one = 4'b0001;

    // Press table: r1 pressed while c2 is driven, key_ready high throughout.
    for (int k = 1; k <= 41; k++) begin
      tbl[k-1].rows = (k >= 9 && k <= 27) ? 4'b0010 : 4'b0000;
      tbl[k-1].rdy  = 1'b1;
      if (k <= 3)       tbl[k-1].cols = 4'b0001;
      else if (k <= 7)  tbl[k-1].cols = 4'b0010;
      else if (k <= 36) tbl[k-1].cols = 4'b0100;
      else if (k <= 40) tbl[k-1].cols = 4'b1000;
      else              tbl[k-1].cols = 4'b0001;
      tbl[k-1].vld  = (k == 23);
      tbl[k-1].code = (k >= 23) ? 4'h6 : 4'h0;
      tbl[k-1].held = (k >= 24 && k <= 36);
    end

    @(negedge clk);

    // Reset state and idle scan rotation.
    do_reset();
    chk("reset cols", 32'(cols), 32'h1);
    chk("reset key_valid", 32'(key_valid), 32'h0);
    chk("reset key_code", 32'(key_code), 32'h0);
    chk("reset key_held", 32'(key_held), 32'h0);
    for (int k = 1; k <= 40; k++) begin
      step(4'd0, 1'b0);
      chk($sformatf("idle cols k=%0d", k), 32'(cols), 32'(one << ((k / 4) % 4)));
      chk($sformatf("idle valid k=%0d", k), 32'(key_valid), 32'h0);
    end

    // Table-driven press of key 6 with ready tied high.
    do_reset();
    for (int i = 0; i < 41; i++) begin
      step(tbl[i].rows, tbl[i].rdy);
      chk($sformatf("tbl cols k=%0d", i + 1), 32'(cols), 32'(tbl[i].cols));
      chk($sformatf("tbl valid k=%0d", i + 1), 32'(key_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl code k=%0d", i + 1), 32'(key_code), 32'(tbl[i].code));
      chk($sformatf("tbl held k=%0d", i + 1), 32'(key_held), 32'(tbl[i].held));
    end
    chk("tbl transfers", 32'(xfers), 32'd1);

    // Press r0/c0 that bounces open on the confirm cycle.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      r = (k <= 14) ? 4'b0001 : 4'b0000;
      step(r, 1'b1);
      chk($sformatf("bounce valid k=%0d", k), 32'(key_valid), 32'h0);
      if (k == 15) chk("bounce cols after confirm", 32'(cols), 32'h1);
      if (k == 16) chk("bounce held", 32'(key_held), 32'h0);
      if (k == 18) chk("bounce cols same column", 32'(cols), 32'h1);
      if (k == 19) chk("bounce cols rotate", 32'(cols), 32'h2);
    end

    // Press r3/c3 with consumer stalled 20 cycles and key released meanwhile.
    do_reset();
    for (int k = 1; k <= 60; k++) begin
      r = (k >= 13 && k <= 28) ? 4'b1000 : 4'b0000;
      step(r, (k >= 47));
      if (k == 20) chk("stall cols frozen", 32'(cols), 32'h8);
      if (k == 26) chk("stall valid before confirm", 32'(key_valid), 32'h0);
      if (k >= 27 && k <= 46) begin
        chk($sformatf("stall valid k=%0d", k), 32'(key_valid), 32'h1);
        chk($sformatf("stall code k=%0d", k), 32'(key_code), 32'hD);
      end
      if (k == 47) begin
        chk("stall valid after xfer", 32'(key_valid), 32'h0);
        chk("stall held after xfer", 32'(key_held), 32'h1);
      end
      if (k == 56) chk("stall held k=56", 32'(key_held), 32'h1);
      if (k == 57) begin
        chk("stall held released", 32'(key_held), 32'h0);
        chk("stall cols wrap", 32'(cols), 32'h1);
      end
    end
    chk("stall transfers", 32'(xfers), 32'd1);

    // Two rows at once: treated as no key, scan keeps rotating.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step(4'b0011, 1'b1);
      chk($sformatf("ghost cols k=%0d", k), 32'(cols), 32'(one << ((k / 4) % 4)));
      chk($sformatf("ghost valid k=%0d", k), 32'(key_valid), 32'h0);
    end

    // Key 1 accepted, then release with a 3-cycle glitch inside the window.
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      if (k <= 16)                r = 4'b0001;
      else if (k >= 24 && k <= 26) r = 4'b0001;
      else                         r = 4'b0000;
      step(r, 1'b1);
      if (k == 15) begin
        chk("glitch valid", 32'(key_valid), 32'h1);
        chk("glitch code", 32'(key_code), 32'h1);
      end
      if (k >= 16) chk($sformatf("glitch no repeat k=%0d", k), 32'(key_valid), 32'h0);
      if (k == 23) chk("glitch held before glitch", 32'(key_held), 32'h1);
      if (k == 26) chk("glitch held during glitch", 32'(key_held), 32'h1);
      if (k == 35) chk("glitch held 9 zeros", 32'(key_held), 32'h1);
      if (k == 36) begin
        chk("glitch held 10 zeros", 32'(key_held), 32'h0);
        chk("glitch cols next", 32'(cols), 32'h2);
      end
    end
    chk("glitch transfers", 32'(xfers), 32'd1);

    // Asynchronous reset while an event is pending.
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      step(4'b0001, 1'b0);
    end
    chk("arst pre valid", 32'(key_valid), 32'h1);
    chk("arst pre cols", 32'(cols), 32'h1);
    rows = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    chk("arst valid", 32'(key_valid), 32'h0);
    chk("arst cols", 32'(cols), 32'h1);
    chk("arst code", 32'(key_code), 32'h0);
    chk("arst held", 32'(key_held), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(4'b0000, 1'b1);
      chk($sformatf("arst dropped k=%0d", k), 32'(key_valid), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
